tile_addr_gen: RTL and testbench

- Sits directly downstream of the tile-index sequencer.
- Accepts one (i, j, k) tile triple per handshake and expands it into per-row vector read addresses for the A and B operand tiles, plus C write-back addresses after the last k tile.
- Drives the operand SRAM read port, accumulator clear, and write-back strobes of the systolic array.
- One tile is TILE x TILE elements. Each SRAM word holds one TILE-wide row segment (VLEN bits).

---
 rtl/tile_addr_gen.sv | 137 +++++++++++++
 tb/tb_tile_addr_gen.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tile_addr_gen.sv
// Expands one (i, j, k) tile triple into A/B operand row reads and, on the last
// reduction step, C write-back rows for a TILE x TILE systolic array.
module tile_addr_gen #(
    parameter int ROW_M  = 8,
    parameter int TILE   = 4,
    parameter int ADDR_W = 8,
    parameter int A_BASE = 0,
    parameter int B_BASE = 64,
    parameter int C_BASE = 128,
    localparam int IDX_W = $clog2(ROW_M)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tile_valid,
    output logic              tile_ready,
    input  logic [IDX_W-1:0]  index_i,
    input  logic [IDX_W-1:0]  index_j,
    input  logic [IDX_W-1:0]  index_k,
    input  logic              tiles_done,
    output logic              rd_en,
    output logic              rd_sel,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              acc_clr,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic              busy,
    output logic              done
);
    localparam int NB      = ROW_M / TILE;
    localparam int TILE_LG = $clog2(TILE);
    localparam int RC_W    = (TILE > 1) ? $clog2(TILE) : 1;

    localparam logic [IDX_W-1:0]  IDX_MASK = ~IDX_W'(TILE - 1);
    localparam logic [IDX_W-1:0]  K_LAST   = IDX_W'(ROW_M - TILE);
    localparam logic [RC_W-1:0]   RC_LAST  = RC_W'(TILE - 1);
    localparam logic [ADDR_W-1:0] NB_A     = ADDR_W'(NB);

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, WB} state_t;

    state_t            state_q, state_d;
    logic [RC_W-1:0]   rc_q, rc_d;
    logic [IDX_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic              init_q;

    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rc_q    <= '0;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rc_q    <= rc_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            last_q  <= last_d;
            done_q  <= done_d;
            init_q  <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        rc_d    = rc_q + RC_W'(1);
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        last_d  = last_q;
        done_d  = done_q;
        unique case (state_q)
            IDLE: begin
                rc_d = '0;
                // An offered triple wins over tiles_done so it is never dropped.
                if (tile_valid && tile_ready) begin
                    i_d     = index_i & IDX_MASK;
                    j_d     = index_j & IDX_MASK;
                    k_d     = index_k & IDX_MASK;
                    last_d  = ((index_k & IDX_MASK) == K_LAST);
                    state_d = LOAD_A;
                end else if (tiles_done && !tile_valid) begin
                    done_d = 1'b1;
                end
            end
            LOAD_A: begin
                if (rc_q == RC_LAST) begin
                    rc_d    = '0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (rc_q == RC_LAST) begin
                    rc_d    = '0;
                    state_d = last_q ? WB : IDLE;
                end
            end
            WB: begin
                if (rc_q == RC_LAST) begin
                    rc_d    = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                rc_d    = '0;
                state_d = IDLE;
            end
        endcase
    end

    // Word address = base + row * words_per_row + column_block, wrapping at ADDR_W.
    assign a_addr = ADDR_W'(A_BASE) + (ADDR_W'(i_q) + ADDR_W'(rc_q)) * NB_A
                    + ADDR_W'(k_q >> TILE_LG);
    assign b_addr = ADDR_W'(B_BASE) + (ADDR_W'(k_q) + ADDR_W'(rc_q)) * NB_A
                    + ADDR_W'(j_q >> TILE_LG);
    assign c_addr = ADDR_W'(C_BASE) + (ADDR_W'(i_q) + ADDR_W'(rc_q)) * NB_A
                    + ADDR_W'(j_q >> TILE_LG);

    assign tile_ready = (state_q == IDLE) && init_q && !done_q;
    assign rd_en      = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign rd_sel     = (state_q == LOAD_B);
    assign rd_addr    = (state_q == LOAD_A) ? a_addr :
                        (state_q == LOAD_B) ? b_addr : '0;
    assign acc_clr    = (state_q == LOAD_A) && (rc_q == '0) && (k_q == '0);
    assign wb_en      = (state_q == WB);
    assign wb_addr    = (state_q == WB) ? c_addr : '0;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_tile_addr_gen.sv
// Directed bench for tile_addr_gen: a scoreboard of expected read/clear/write-back
// cycles is filled on acceptance and drained by a negedge monitor.
module tb_tile_addr_gen;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tile_valid = 1'b0;
    logic       tile_ready;
    logic [2:0] index_i = '0, index_j = '0, index_k = '0;
    logic       tiles_done = 1'b0;
    logic       rd_en, rd_sel, acc_clr, wb_en, busy, done;
    logic [7:0] rd_addr, wb_addr;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       rd;
        logic       sel;
        logic       wb;
        logic       clr;
        logic [7:0] ra;
        logic [7:0] wa;
    } ev_t;

    ev_t q[$];

    tile_addr_gen dut (
        .clk(clk), .reset(reset), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .index_i(index_i), .index_j(index_j), .index_k(index_k),
        .tiles_done(tiles_done), .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
        .acc_clr(acc_clr), .wb_en(wb_en), .wb_addr(wb_addr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stream for one triple (A rows, B rows, then C rows when k is last).
    task automatic push_tile(input int i, input int j, input int k, input int lim);
        int im = i & ~3, jm = j & ~3, km = k & ~3;
        int n = 0;
        ev_t e;
        for (int rc = 0; rc < 4; rc++) begin
            e = '{rd: 1'b1, sel: 1'b0, wb: 1'b0, clr: (rc == 0 && km == 0),
                  ra: 8'((im + rc) * 2 + km / 4), wa: 8'd0};
            if (n < lim) q.push_back(e);
            n++;
        end
        for (int rc = 0; rc < 4; rc++) begin
            e = '{rd: 1'b1, sel: 1'b1, wb: 1'b0, clr: 1'b0,
                  ra: 8'(64 + (km + rc) * 2 + jm / 4), wa: 8'd0};
            if (n < lim) q.push_back(e);
            n++;
        end
        if (km == 4) begin
            for (int rc = 0; rc < 4; rc++) begin
                e = '{rd: 1'b0, sel: 1'b0, wb: 1'b1, clr: 1'b0,
                      ra: 8'd0, wa: 8'(128 + (im + rc) * 2 + jm / 4)};
                if (n < lim) q.push_back(e);
                n++;
            end
        end
    endtask

    always @(negedge clk) begin
        ev_t o, e;
        if (rd_en || wb_en || acc_clr) begin
            o = '{rd: rd_en, sel: rd_sel, wb: wb_en, clr: acc_clr, ra: rd_addr, wa: wb_addr};
            if (q.size() == 0) begin
                chk("unexpected_event", 32'(o), 32'h0);
            end else begin
                e = q.pop_front();
                chk("event", 32'(o), 32'(e));
            end
        end
    end

    // Called at a negedge; returns at the first idle negedge after the tile.
    task automatic send(input int i, input int j, input int k, input bit hold, input bit fin);
        int n = 0;
        tile_valid = 1'b1;
        index_i = 3'(i);
        index_j = 3'(j);
        index_k = 3'(k);
        tiles_done = fin;
        while (!tile_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", 32'(n < 64), 32'd1);
        push_tile(i, j, k, 99);
        @(posedge clk);
        #1;
        if (!hold) tile_valid = 1'b0;
        @(negedge clk);
        n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge clk);
        end
        chk("busy_cycles", 32'(n), ((k & ~3) == 4) ? 32'd12 : 32'd8);
    endtask

    initial begin
        // Reset held for three cycles.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {tile_ready, rd_en, rd_sel, rd_addr, acc_clr, wb_en, wb_addr, busy, done}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", {31'b0, tile_ready}, 32'd1);
        chk("idle_addrs", {rd_sel, rd_addr, wb_addr}, 32'h0);

        send(0, 0, 0, 1'b0, 1'b0);
        chk("ready_after_000", {31'b0, tile_ready}, 32'd1);
        send(0, 4, 4, 1'b0, 1'b0);
        chk("ready_after_044", {31'b0, tile_ready}, 32'd1);
        // Low index bits are ignored: (5,7,6) behaves as (4,4,4).
        send(5, 7, 6, 1'b0, 1'b0);

        // Back-to-back with tile_valid held high.
        send(4, 0, 0, 1'b1, 1'b0);
        chk("b2b_idle_gap", {30'b0, tile_ready, busy}, 32'b10);
        send(0, 4, 0, 1'b1, 1'b0);
        tile_valid = 1'b0;

        // Reset during the second LOAD_B cycle.
        tile_valid = 1'b1;
        index_i = 3'd0; index_j = 3'd0; index_k = 3'd0;
        push_tile(0, 0, 0, 5);
        @(posedge clk);
        #1 tile_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_rd_en", {30'b0, rd_en, busy}, 32'd0);
        @(negedge clk);
        chk("abort_outputs", {tile_ready, rd_en, rd_sel, rd_addr, acc_clr, wb_en, wb_addr, busy, done}, 32'h0);
        reset = 1'b1;
        @(negedge clk);
        chk("after_abort", {29'b0, tile_ready, busy, done}, 32'b100);
        chk("abort_sb_empty", 32'(q.size()), 32'd0);

        // Full 8-triple run; tiles_done arrives alongside the final triple.
        for (int ii = 0; ii < 8; ii += 4)
            for (int jj = 0; jj < 8; jj += 4)
                for (int kk = 0; kk < 8; kk += 4)
                    send(ii, jj, kk, 1'b0, (ii == 4 && jj == 4 && kk == 4));
        chk("done_not_yet", {31'b0, done}, 32'd0);
        @(negedge clk);
        chk("done_set", {30'b0, done, tile_ready}, 32'b10);
        tile_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("done_sticky", {29'b0, done, tile_ready, busy}, 32'b100);
        tile_valid = 1'b0;
        chk("sb_empty", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: simulation did not finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
